// File: rtl/jtframe_db9_pkg.sv
// Shared types and constants for the DB9 controller sequencer and player arbiters.
package jtframe_db9_pkg;

    localparam int JOY_W = 12;

    typedef logic [JOY_W-1:0] joy_t;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SCAN   = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    // Bit layout of a joystick word
    localparam int DIR_LSB   = 0;
    localparam int DIR_MSB   = 3;
    localparam int BTN_LSB   = 4;
    localparam int BTN_MSB   = 6;
    localparam int START_BIT = 10;
    localparam int MODE_BIT  = 11;

    function automatic logic joy_active(input joy_t w);
        return |w;
    endfunction

endpackage

// File: rtl/jtframe_db9ctrl_if.sv
// Signal bundle between the DB9 controller, the reader, the OSD/USB side and the core.
interface jtframe_db9ctrl_if;
    import jtframe_db9_pkg::*;

    logic       en;
    joy_t       usb_joy0;
    joy_t       usb_joy1;
    joy_t       db9_joy0;
    joy_t       db9_joy1;
    logic       sample;
    logic       cen_hs;
    logic       scan;
    joy_t       joy0;
    joy_t       joy1;
    logic [1:0] owner;
    logic       fault;

    modport master (
        output en, usb_joy0, usb_joy1, db9_joy0, db9_joy1, sample,
        input  cen_hs, scan, joy0, joy1, owner, fault
    );

    modport slave (
        input  en, usb_joy0, usb_joy1, db9_joy0, db9_joy1, sample,
        output cen_hs, scan, joy0, joy1, owner, fault
    );

endinterface

// File: rtl/jtframe_db9arb.sv
// Per-player source arbiter: tracks DB9 ownership with an idle timeout and muxes
// the latched DB9 word against the live USB word.
module jtframe_db9arb
    import jtframe_db9_pkg::*;
#(
    parameter int IDLE_SAMPLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic proc,
    input  joy_t db9,
    input  joy_t usb,
    output logic owner,
    output joy_t joy
);

    localparam int IDLE_W = $clog2(IDLE_SAMPLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_SAMPLES);

    logic              owner_reg, owner_next;
    logic [IDLE_W-1:0] idle_reg, idle_next;
    joy_t              latch_reg, latch_next;
    joy_t              joy_reg, joy_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg <= 1'b0;
            idle_reg  <= '0;
            latch_reg <= '0;
            joy_reg   <= '0;
        end else begin
            owner_reg <= owner_next;
            idle_reg  <= idle_next;
            latch_reg <= latch_next;
            joy_reg   <= joy_next;
        end
    end

    always_comb begin
        owner_next = owner_reg;
        idle_next  = idle_reg;
        latch_next = latch_reg;
        if (clr) begin
            owner_next = 1'b0;
            idle_next  = '0;
        end else if (proc) begin
            latch_next = db9;
            // DB9 activity beats USB activity on the same sample
            if (joy_active(db9)) begin
                owner_next = 1'b1;
                idle_next  = '0;
            end else if (joy_active(usb)) begin
                owner_next = 1'b0;
                idle_next  = '0;
            end else if (owner_reg) begin
                if (idle_reg != IDLE_MAX) begin
                    idle_next = idle_reg + 1'b1;
                end
                if (idle_next == IDLE_MAX) begin
                    owner_next = 1'b0;
                end
            end
        end
        joy_next = owner_reg ? latch_reg : usb;
    end

    assign owner = owner_reg;
    assign joy   = joy_reg;

endmodule

// File: rtl/jtframe_db9ctrl.sv
// DB9 reader sequencer: line tick, settle/scan/fault sequencing with strobe
// timeout and retry, plus two per-player USB/DB9 arbiters.
module jtframe_db9ctrl
    import jtframe_db9_pkg::*;
#(
    parameter int CLK_DIV      = 3072,
    parameter int SETTLE_TICKS = 16,
    parameter int TOUT_TICKS   = 128,
    parameter int RETRY_TICKS  = 1024,
    parameter int IDLE_SAMPLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    jtframe_db9ctrl_if.slave  bus
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int SEQ_MAX = (RETRY_TICKS > SETTLE_TICKS) ? RETRY_TICKS : SETTLE_TICKS;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int TOUT_W  = $clog2(TOUT_TICKS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [SEQ_W-1:0]  SETTLE_LAST = SEQ_W'(SETTLE_TICKS - 1);
    localparam logic [SEQ_W-1:0]  RETRY_LAST  = SEQ_W'(RETRY_TICKS - 1);
    localparam logic [TOUT_W-1:0] TOUT_MAX    = TOUT_W'(TOUT_TICKS);

    logic [DIV_W-1:0]  div_reg;
    logic              cen_reg;
    state_t            state_reg, state_next;
    logic [SEQ_W-1:0]  seq_reg, seq_next;
    logic [TOUT_W-1:0] tout_reg, tout_next;
    logic              smp_reg;
    logic              clr;

    // Free-running line tick, independent of the sequencer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            cen_reg <= 1'b0;
        end else begin
            cen_reg <= (div_reg == DIV_LAST);
            div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_OFF;
            seq_reg   <= '0;
            tout_reg  <= '0;
            smp_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            seq_reg   <= seq_next;
            tout_reg  <= tout_next;
            smp_reg   <= bus.sample && (state_reg == ST_SCAN);
        end
    end

    always_comb begin
        state_next = state_reg;
        seq_next   = seq_reg;
        tout_next  = tout_reg;
        if (!bus.en) begin
            state_next = ST_OFF;
            seq_next   = '0;
            tout_next  = '0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    state_next = ST_SETTLE;
                    seq_next   = '0;
                end
                ST_SETTLE: begin
                    if (cen_reg) begin
                        if (seq_reg == SETTLE_LAST) begin
                            state_next = ST_SCAN;
                            seq_next   = '0;
                            tout_next  = '0;
                        end else begin
                            seq_next = seq_reg + 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    // A strobe on the boundary tick still counts as a strobe
                    if (bus.sample) begin
                        tout_next = '0;
                    end else if (cen_reg) begin
                        if (tout_reg != TOUT_MAX) begin
                            tout_next = tout_reg + 1'b1;
                        end
                        if (tout_next == TOUT_MAX) begin
                            state_next = ST_FAULT;
                            seq_next   = '0;
                        end
                    end
                end
                ST_FAULT: begin
                    if (cen_reg) begin
                        if (seq_reg == RETRY_LAST) begin
                            state_next = ST_SETTLE;
                            seq_next   = '0;
                        end else begin
                            seq_next = seq_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ST_OFF;
                    seq_next   = '0;
                    tout_next  = '0;
                end
            endcase
        end
    end

    // Ownership drops on the same edge that enters FAULT or leaves enable
    assign clr = !bus.en || (state_next == ST_FAULT);

    joy_t       db9_w [2];
    joy_t       usb_w [2];
    joy_t       joy_w [2];
    logic [1:0] own_w;

    assign db9_w[0] = bus.db9_joy0;
    assign db9_w[1] = bus.db9_joy1;
    assign usb_w[0] = bus.usb_joy0;
    assign usb_w[1] = bus.usb_joy1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_arb
            jtframe_db9arb #(
                .IDLE_SAMPLES(IDLE_SAMPLES)
            ) u_arb (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .proc  (smp_reg),
                .db9   (db9_w[gi]),
                .usb   (usb_w[gi]),
                .owner (own_w[gi]),
                .joy   (joy_w[gi])
            );
        end
    endgenerate

    assign bus.cen_hs = cen_reg;
    assign bus.scan   = (state_reg == ST_SCAN);
    assign bus.fault  = (state_reg == ST_FAULT);
    assign bus.owner  = own_w;
    assign bus.joy0   = joy_w[0];
    assign bus.joy1   = joy_w[1];

endmodule

// File: tb/tb_jtframe_db9ctrl.sv
// Directed bench for jtframe_db9ctrl: tick, sequencing, timeout/retry, arbitration, reset.
module tb_jtframe_db9ctrl;
    import jtframe_db9_pkg::*;

    localparam int CLK_DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    jtframe_db9ctrl_if bus();

    jtframe_db9ctrl #(
        .CLK_DIV      (CLK_DIV),
        .SETTLE_TICKS (16),
        .TOUT_TICKS   (128),
        .RETRY_TICKS  (1024),
        .IDLE_SAMPLES (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %-16s val=%0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge where the n-th tick is visible (not yet consumed)
    task automatic wait_ticks(input int n);
        int seen;
        int budget;
        seen   = 0;
        budget = (n + 2) * CLK_DIV;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.cen_hs) seen++;
        end
        if (seen < n) chk("tick_budget", seen, n);
    endtask

    // Strobe for one clk; returns when the resulting ownership is visible
    task automatic do_sample();
        bus.sample = 1'b1;
        step(1);
        bus.sample = 1'b0;
        step(1);
    endtask

    initial begin
        int cen_cnt;
        int last;
        int bad;
        int scan_hi;

        bus.en       = 1'b0;
        bus.usb_joy0 = '0;
        bus.usb_joy1 = '0;
        bus.db9_joy0 = '0;
        bus.db9_joy1 = '0;
        bus.sample   = 1'b0;

        step(2);
        chk("rst_scan",   bus.scan,   0);
        chk("rst_cen",    bus.cen_hs, 0);
        chk("rst_owner",  bus.owner,  0);
        chk("rst_fault",  bus.fault,  0);
        chk("rst_joy0",   bus.joy0,   0);
        chk("rst_joy1",   bus.joy1,   0);
        rst = 1'b0;

        // Tick period and scan held low while disabled
        cen_cnt = 0; last = -1; bad = 0; scan_hi = 0;
        for (int i = 0; i < 160; i++) begin
            step(1);
            if (bus.cen_hs) begin
                if (last < 0 && i != CLK_DIV - 1) bad++;
                if (last >= 0 && i - last != CLK_DIV) bad++;
                last = i;
                cen_cnt++;
            end
            if (bus.scan) scan_hi++;
        end
        chk("cen_count",  cen_cnt, 20);
        chk("cen_gap",    bad,     0);
        chk("scan_en0",   scan_hi, 0);

        // Settle takes 16 ticks
        bus.en = 1'b1;
        wait_ticks(16);
        chk("scan_settle", bus.scan, 0);
        step(1);
        chk("scan_on",     bus.scan, 1);

        // USB pass-through every cycle
        bus.usb_joy1 = 12'h0F0;
        step(1);
        chk("joy1_usb",    bus.joy1, 12'h0F0);

        // DB9 takes player 1
        bus.db9_joy0 = 12'h001;
        do_sample();
        chk("owner_db9",   bus.owner, 2'b01);
        chk("joy0_lag",    bus.joy0,  12'h000);
        step(1);
        chk("joy0_db9",    bus.joy0,  12'h001);

        // Idle release on the 4th zero sample
        bus.db9_joy0 = '0;
        repeat (3) do_sample();
        chk("owner_idle3", bus.owner, 2'b01);
        do_sample();
        chk("owner_idle4", bus.owner, 2'b00);

        // USB activity releases DB9 ownership at the next sample
        bus.db9_joy0 = 12'h001;
        do_sample();
        bus.db9_joy0 = '0;
        do_sample();
        chk("owner_idle1", bus.owner, 2'b01);
        bus.usb_joy0 = 12'h004;
        step(1);
        chk("joy0_hold",   bus.joy0,  12'h000);
        do_sample();
        chk("owner_usb",   bus.owner, 2'b00);
        step(1);
        chk("joy0_usb",    bus.joy0,  12'h004);

        // DB9 and USB both active on player 2: DB9 wins
        bus.usb_joy1 = 12'h020;
        bus.db9_joy1 = 12'h010;
        do_sample();
        chk("owner_both",  bus.owner, 2'b10);
        step(1);
        chk("joy1_both",   bus.joy1,  12'h010);

        bus.usb_joy0 = '0;
        bus.db9_joy0 = 12'h001;
        do_sample();
        chk("owner_11",    bus.owner, 2'b11);

        // Strobe on the timeout tick prevents a fault
        wait_ticks(1);
        bus.sample = 1'b1;
        step(1);
        bus.sample = 1'b0;
        wait_ticks(128);
        bus.sample = 1'b1;
        step(1);
        bus.sample = 1'b0;
        step(2);
        chk("fault_bnd",   bus.fault, 0);
        chk("scan_bnd",    bus.scan,  1);

        // Timeout after 128 silent ticks
        wait_ticks(127);
        step(1);
        chk("fault_early", bus.fault, 0);
        wait_ticks(1);
        step(1);
        chk("fault_on",    bus.fault, 1);
        chk("scan_flt",    bus.scan,  0);
        chk("owner_flt",   bus.owner, 2'b00);
        do_sample();
        chk("owner_ign",   bus.owner, 2'b00);

        // Retry after 1024 ticks, then settle again
        wait_ticks(1024);
        chk("fault_ret",   bus.fault, 1);
        step(1);
        chk("fault_off",   bus.fault, 0);
        chk("scan_reset",  bus.scan,  0);
        wait_ticks(16);
        step(1);
        chk("scan_retry",  bus.scan,  1);

        do_sample();
        chk("owner_re",    bus.owner, 2'b11);
        step(1);

        // Asynchronous reset mid-scan
        #2;
        rst = 1'b1;
        #1;
        chk("arst_scan",   bus.scan,   0);
        chk("arst_cen",    bus.cen_hs, 0);
        chk("arst_owner",  bus.owner,  0);
        chk("arst_fault",  bus.fault,  0);
        chk("arst_joy0",   bus.joy0,   0);
        chk("arst_joy1",   bus.joy1,   0);
        step(2);
        rst = 1'b0;
        step(1);
        chk("post_scan",   bus.scan,  0);
        chk("post_owner",  bus.owner, 0);
        wait_ticks(16);
        chk("post_settle", bus.scan,  0);
        step(1);
        chk("post_scanon", bus.scan,  1);

        // Disable drops scan and ownership on the next clk
        do_sample();
        chk("owner_pre",   bus.owner, 2'b11);
        bus.en = 1'b0;
        step(1);
        chk("scan_en_off", bus.scan,  0);
        chk("owner_en_off", bus.owner, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
